// File: rtl/usb_tx_if.sv
// Byte handshake between the protocol engine and the usb_tx serializer.
// txAcceptData pulses for the cycle in which txData/txDataValid are consumed.
interface usb_tx_if;
  logic       txReqSendPacket;
  logic       txDataValid;
  logic [7:0] txData;
  logic       txAcceptData;
  logic       txBusy;

  modport master (
    output txReqSendPacket, txDataValid, txData,
    input  txAcceptData, txBusy
  );

  modport slave (
    input  txReqSendPacket, txDataValid, txData,
    output txAcceptData, txBusy
  );
endinterface

// File: rtl/usb_tx.sv
// Full-speed USB transmitter: SYNC, stuffed NRZI bytes, EOP; one bit per clk12.
// Optional automatic CRC16 on data packets under `define USB_TX_AUTO_CRC16_EN.
module usb_tx #(
  parameter logic [7:0] SYNC_VALUE   = 8'h80,
  parameter int         EOP_SE0_BITS = 2
) (
  input  logic       clk12,
  input  logic       RST,
  usb_tx_if.slave    tx,
  output logic       dataOutP,
  output logic       dataOutN,
  output logic       outEN_reg,
  output logic [2:0] state_dbg
);
  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_SYNC    = 3'd1,
    TX_DATA    = 3'd2,
    TX_CRC     = 3'd3,
    TX_EOP_SE0 = 3'd4,
    TX_EOP_J   = 3'd5
  } state_t;

  localparam logic [1:0] SE0_LAST = 2'(EOP_SE0_BITS - 1);

  state_t      state;
  logic [7:0]  shift;
  logic [3:0]  bit_cnt;
  logic [2:0]  ones;
  logic        level;        // NRZI line level, 1 = J
  logic        end_pending;  // last bit made six ones; one stuff bit still owed
  logic [1:0]  se0_cnt;

  logic        stuff;
  logic        cur_bit;
  logic [2:0]  ones_next;
  logic        level_next;
  logic        boundary;
  logic        last_bit;

`ifdef USB_TX_AUTO_CRC16_EN
  logic [15:0] crc;
  logic [15:0] crc_next;
  logic        crc_on;
  logic        pid_byte;
  logic        to_crc;
`endif

  always_comb begin
    stuff = (ones == 3'd6);
`ifdef USB_TX_AUTO_CRC16_EN
    cur_bit = (state == TX_CRC) ? ~crc[0] : shift[0];
`else
    cur_bit = shift[0];
`endif
    ones_next  = cur_bit ? ones + 3'd1 : 3'd0;
    level_next = (stuff || !cur_bit) ? ~level : level;
    boundary   = (state == TX_SYNC || state == TX_DATA) && !stuff && (bit_cnt == 4'd7);
`ifdef USB_TX_AUTO_CRC16_EN
    // Reflected CRC16 (0xA001 == bit-reversed 0x8005), residue shifted out LSB first
    crc_next = {1'b0, crc[15:1]} ^ ((cur_bit ^ crc[0]) ? 16'hA001 : 16'h0000);
    to_crc   = boundary && !tx.txDataValid && crc_on;
    last_bit = (boundary && !tx.txDataValid && !crc_on) ||
               (state == TX_CRC && !stuff && bit_cnt == 4'd15);
`else
    last_bit = boundary && !tx.txDataValid;
`endif
  end

  assign tx.txAcceptData = boundary && tx.txDataValid && !RST;
  assign state_dbg       = state;

  always_ff @(posedge clk12) begin
    if (RST) begin
      state       <= TX_IDLE;
      dataOutP    <= 1'b1;
      dataOutN    <= 1'b0;
      outEN_reg   <= 1'b0;
      tx.txBusy   <= 1'b0;
      shift       <= 8'h00;
      bit_cnt     <= 4'd0;
      ones        <= 3'd0;
      level       <= 1'b1;
      end_pending <= 1'b0;
      se0_cnt     <= 2'd0;
`ifdef USB_TX_AUTO_CRC16_EN
      crc         <= 16'hFFFF;
      crc_on      <= 1'b0;
      pid_byte    <= 1'b0;
`endif
    end else begin
      case (state)
        TX_IDLE: begin
          dataOutP    <= 1'b1;
          dataOutN    <= 1'b0;
          outEN_reg   <= 1'b0;
          tx.txBusy   <= 1'b0;
          level       <= 1'b1;
          end_pending <= 1'b0;
          // txBusy is still high during the cycle after EOP, so a held request is dropped
          if (tx.txReqSendPacket && !tx.txBusy) begin
            shift     <= SYNC_VALUE;
            bit_cnt   <= 4'd0;
            ones      <= 3'd0;
            tx.txBusy <= 1'b1;
            state     <= TX_SYNC;
`ifdef USB_TX_AUTO_CRC16_EN
            crc_on    <= 1'b0;
`endif
          end
        end
`ifdef USB_TX_AUTO_CRC16_EN
        TX_SYNC, TX_DATA, TX_CRC: begin
`else
        TX_SYNC, TX_DATA: begin
`endif
          outEN_reg <= 1'b1;
          dataOutP  <= level_next;
          dataOutN  <= ~level_next;
          level     <= level_next;
          if (stuff) begin
            ones <= 3'd0;
            if (end_pending) begin
              end_pending <= 1'b0;
              se0_cnt     <= 2'd0;
              state       <= TX_EOP_SE0;
            end
          end else begin
            ones    <= ones_next;
            shift   <= {1'b0, shift[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
`ifdef USB_TX_AUTO_CRC16_EN
            if (state == TX_DATA && crc_on && !pid_byte) crc <= crc_next;
            if (state == TX_CRC) crc <= {1'b0, crc[15:1]};
`endif
            if (boundary && tx.txDataValid) begin
              shift   <= tx.txData;
              bit_cnt <= 4'd0;
              state   <= TX_DATA;
`ifdef USB_TX_AUTO_CRC16_EN
              if (state == TX_SYNC) begin
                pid_byte <= 1'b1;
                crc_on   <= (tx.txData[1:0] == 2'b11);
                crc      <= 16'hFFFF;
              end else begin
                pid_byte <= 1'b0;
              end
`endif
            end
`ifdef USB_TX_AUTO_CRC16_EN
            if (to_crc) begin
              bit_cnt <= 4'd0;
              state   <= TX_CRC;
            end
`endif
            if (last_bit) begin
              if (ones_next == 3'd6) begin
                end_pending <= 1'b1;
              end else begin
                se0_cnt <= 2'd0;
                state   <= TX_EOP_SE0;
              end
            end
          end
        end
        TX_EOP_SE0: begin
          dataOutP  <= 1'b0;
          dataOutN  <= 1'b0;
          outEN_reg <= 1'b1;
          if (se0_cnt == SE0_LAST) state <= TX_EOP_J;
          else se0_cnt <= se0_cnt + 2'd1;
        end
        TX_EOP_J: begin
          dataOutP  <= 1'b1;
          dataOutN  <= 1'b0;
          outEN_reg <= 1'b1;
          level     <= 1'b1;
          state     <= TX_IDLE;
        end
        default: state <= TX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_tx.sv
// Bench for usb_tx: directed packet table, hand-written corner sequences and
// random packets, all checked against a bit-list model of SYNC/stuffing/NRZI/EOP.
module tb_usb_tx;
  localparam int SE0_BITS = 2;
  localparam logic [1:0] SYM_J = 2'b10;
  localparam logic [1:0] SYM_K = 2'b01;

  logic       clk12 = 1'b0;
  logic       RST;
  logic       dataOutP, dataOutN, outEN_reg;
  logic [2:0] state_dbg;

  usb_tx_if bus();

  usb_tx dut (
    .clk12     (clk12),
    .RST       (RST),
    .tx        (bus.slave),
    .dataOutP  (dataOutP),
    .dataOutN  (dataOutN),
    .outEN_reg (outEN_reg),
    .state_dbg (state_dbg)
  );

  always #5 clk12 = ~clk12;

  typedef struct {
    string       name;
    int          n;
    logic [23:0] bytes;   // byte 0 (PID) in [7:0]
    int          exp_len; // hand-counted outEN_reg cycles
  } vec_t;

  vec_t       tbl[6];
  logic [7:0] pkt[$];
  logic [1:0] got_q[$];
  logic [1:0] exp_q[$];
  int         vec_cnt, miss_cnt;
  int         idx, acc_cnt, first_en, busy_cnt, cyc;
  logic       last_busy, hold_req;

  task automatic check(input string name, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: bit list -> stuff after six ones -> NRZI -> SE0s -> J
  function automatic void build_expected();
    logic [7:0] b;
    logic       raw[$];
    logic       stf[$];
    int         ones;
    logic       lvl;
    exp_q.delete();
    b = 8'h80;
    for (int i = 0; i < 8; i++) raw.push_back(b[i]);
    foreach (pkt[k]) begin
      b = pkt[k];
      for (int i = 0; i < 8; i++) raw.push_back(b[i]);
    end
    ones = 0;
    foreach (raw[i]) begin
      stf.push_back(raw[i]);
      ones = raw[i] ? ones + 1 : 0;
      if (ones == 6) begin
        stf.push_back(1'b0);
        ones = 0;
      end
    end
    lvl = 1'b1;
    foreach (stf[i]) begin
      if (!stf[i]) lvl = ~lvl;
      exp_q.push_back(lvl ? SYM_J : SYM_K);
    end
    for (int i = 0; i < SE0_BITS; i++) exp_q.push_back(2'b00);
    exp_q.push_back(SYM_J);
  endfunction

  task automatic tick();
    @(negedge clk12);
    bus.txReqSendPacket = hold_req && last_busy;
    bus.txDataValid     = (idx < pkt.size());
    bus.txData          = (idx < pkt.size()) ? pkt[idx] : 8'h00;
    #1;
    cyc++;
    if (bus.txAcceptData) begin
      acc_cnt++;
      idx++;
    end
    if (outEN_reg) begin
      if (first_en < 0) first_en = cyc;
      got_q.push_back({dataOutP, dataOutN});
    end
    if (bus.txBusy) busy_cnt++;
    last_busy = bus.txBusy;
  endtask

  task automatic start_packet();
    got_q.delete();
    idx = 0; acc_cnt = 0; first_en = -1; busy_cnt = 0; cyc = 0; last_busy = 1'b0;
    @(negedge clk12);
    bus.txReqSendPacket = 1'b1;
    bus.txDataValid     = (pkt.size() > 0);
    bus.txData          = (pkt.size() > 0) ? pkt[0] : 8'h00;
  endtask

  task automatic run_packet(input logic hold);
    logic done;
    hold_req = hold;
    start_packet();
    done = 1'b0;
    while (!done && cyc < 300) begin
      tick();
      if (!bus.txBusy && cyc > 1) done = 1'b1;
    end
    bus.txReqSendPacket = 1'b0;
    hold_req = 1'b0;
    if (!done) check("packet_timeout", 1, 0);
  endtask

  task automatic check_packet(input string name, input int hand_len);
    int n;
    build_expected();
    check({name, " en_cycles"}, got_q.size(), exp_q.size());
    if (hand_len >= 0) check({name, " hand_len"}, got_q.size(), hand_len);
    check({name, " accepts"}, acc_cnt, pkt.size());
    check({name, " first_bit_cycle"}, first_en, 2);
    check({name, " busy_cycles"}, busy_cnt, exp_q.size() + 1);
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s sym%0d", name, i), int'(got_q[i]), int'(exp_q[i]));
  endtask

  task automatic check_ack_line(input string name);
    logic [15:0] ack_kj;
    ack_kj = 16'b1010101100100111; // KJKJKJKK JJKJJKKK, K = 1
    for (int i = 0; i < 16; i++)
      check($sformatf("%s kj%0d", name, i),
            (i < got_q.size()) ? int'(got_q[i]) : -1,
            int'(ack_kj[15 - i] ? SYM_K : SYM_J));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, gap;
    vec_cnt = 0; miss_cnt = 0;
    hold_req = 1'b0; last_busy = 1'b0; idx = 0; cyc = 0;
    acc_cnt = 0; busy_cnt = 0; first_en = -1;
    RST = 1'b1;
    bus.txReqSendPacket = 1'b0;
    bus.txDataValid     = 1'b0;
    bus.txData          = 8'h00;

    tbl[0] = '{"ack",      1, 24'h0000D2, 19};
    tbl[1] = '{"stuff_ff", 2, 24'h00FF4B, 28};
    tbl[2] = '{"stuff_end",2, 24'h00FC4B, 28};
    tbl[3] = '{"bare_sync",0, 24'h000000, 11};
    tbl[4] = '{"triple",   3, 24'hFFFFC3, 38};
    tbl[5] = '{"no_stuff", 2, 24'h00A5A5 & 24'h00_00FF | 24'h000000, 27};
    tbl[5].bytes = 24'h0000A5; // {A5, 00}

    repeat (3) @(negedge clk12);
    #1;
    check("reset P", int'(dataOutP), 1);
    check("reset N", int'(dataOutN), 0);
    check("reset outEN", int'(outEN_reg), 0);
    check("reset busy", int'(bus.txBusy), 0);
    check("reset accept", int'(bus.txAcceptData), 0);
    @(negedge clk12);
    RST = 1'b0;

    for (int t = 0; t < 6; t++) begin
      pkt.delete();
      for (int j = 0; j < tbl[t].n; j++) pkt.push_back(tbl[t].bytes[8*j +: 8]);
      run_packet(1'b0);
      check_packet(tbl[t].name, tbl[t].exp_len);
    end

    // Request held through the whole packet, then a new one right after busy falls
    pkt.delete(); pkt.push_back(8'hD2);
    run_packet(1'b1);
    check_packet("held_req", 19);
    run_packet(1'b0);
    check_packet("b2b", 19);
    check_ack_line("b2b");
    pkt.delete();
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("idle_after_b2b en%0d", i), int'(outEN_reg), 0);
    end

    // Reset during payload bit 3
    pkt.delete(); pkt.push_back(8'h4B); pkt.push_back(8'hA5);
    hold_req = 1'b0;
    start_packet();
    for (int i = 0; i < 20; i++) tick();
    build_expected();
    for (int i = 0; i < got_q.size(); i++)
      check($sformatf("pre_rst sym%0d", i), int'(got_q[i]), int'(exp_q[i]));
    @(negedge clk12);
    RST = 1'b1;
    #1;
    check("rst accept", int'(bus.txAcceptData), 0);
    @(negedge clk12);
    RST = 1'b0;
    #1;
    check("rst P", int'(dataOutP), 1);
    check("rst N", int'(dataOutN), 0);
    check("rst outEN", int'(outEN_reg), 0);
    check("rst busy", int'(bus.txBusy), 0);
    pkt.delete();
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("post_rst en%0d", i), int'(outEN_reg), 0);
      check($sformatf("post_rst P%0d", i), int'(dataOutP), 1);
    end
    pkt.push_back(8'hD2);
    run_packet(1'b0);
    check_packet("ack_after_rst", 19);
    check_ack_line("ack_after_rst");

    // Random packets, biased toward 0xFF to exercise stuffing across bytes
    for (int p = 0; p < 25; p++) begin
      pkt.delete();
      n = $urandom_range(0, 6);
      for (int j = 0; j < n; j++)
        pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      run_packet(1'b0);
      check_packet($sformatf("rnd%0d", p), -1);
      pkt.delete();
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule

// File: doc/usb_tx.md
Name: usb_tx

Overview:
- Full-speed USB serial transmitter; the transmit-direction counterpart of the SIE receive path.
- Accepts packet bytes (PID first) from the protocol engine through a byte handshake.
- Per packet it emits SYNC, then the bytes LSB first with bit stuffing and NRZI encoding, then EOP. It drives the D+/D- pair and the output-enable.
- Runs at one bit time per clk12 cycle; outEN_reg feeds the receiver's DPLL reset.

Parameters:
- SYNC_VALUE, 8'h80: SYNC byte, sent LSB first (7 zeros, then a one).
- EOP_SE0_BITS, 2: number of SE0 bit times in EOP (legal range 1..3).

Ports:
- clk12  input  1  bit clock; single clock domain.
- RST  input  1  synchronous reset, active-high.
- txReqSendPacket  input  1  start-of-packet request; sampled only in TX_IDLE.
- txDataValid  input  1  txData holds a valid byte; low at a byte boundary means end of payload.
- txData  input  8  next byte to send (PID first).
- txAcceptData  output  1  combinational; high for one cycle when txData is consumed.
- txBusy  output  1  high from request acceptance until the last EOP J bit completes.
- dataOutP  output  1  D+ drive.
- dataOutN  output  1  D- drive.
- outEN_reg  output  1  registered line-driver enable.

Behaviour:
- Reset values:
  - state = TX_IDLE.
  - dataOutP = 1, dataOutN = 0 (J).
  - outEN_reg = 0, txBusy = 0, txAcceptData = 0.
  - Ones counter = 0, NRZI level = J.
- All outputs except txAcceptData are registered. A reset asserted mid-packet returns everything to the reset values on the next edge, with no EOP emitted.
- States: TX_IDLE, TX_SYNC, TX_DATA, TX_CRC (optional feature only), TX_EOP_SE0, TX_EOP_J.
- TX_IDLE:
  - Line is held at J, outEN_reg = 0.
  - When txReqSendPacket = 1: load SYNC_VALUE into the shift register, bit counter = 0, ones counter = 0, then go to TX_SYNC. txBusy rises on that same edge.
  - The first SYNC bit appears on the line one cycle after the request is sampled.
- Per emitted bit (TX_SYNC, TX_DATA, TX_CRC):
  - outEN_reg = 1.
  - NRZI: a 0 toggles the line (J<->K), a 1 holds it. J = P1/N0, K = P0/N1.
  - Bit stuffing: after 6 consecutive 1s, the next bit time carries a stuffed 0. During that bit the shift register and bit counter hold, and the ones counter resets.
  - The ones counter also resets on every emitted 0. It counts across byte boundaries, starting from the SYNC bits.
- Byte boundary: the cycle where bit counter = 7 and no stuff bit is inserted.
  - If txDataValid = 1: txAcceptData = 1, load txData, bit counter = 0, state = TX_DATA.
  - If txDataValid = 0: go to TX_EOP_SE0, or to TX_CRC as described under Optional Feature.
  - A missing PID at the end of SYNC still produces a bare SYNC followed by EOP.
- End of payload: if the final data bit completes a run of 6 ones, the stuffed 0 is emitted before EOP.
- TX_EOP_SE0: P = 0, N = 0 for EOP_SE0_BITS cycles, then TX_EOP_J.
- TX_EOP_J: one cycle of J with outEN_reg = 1. On the next edge: TX_IDLE, outEN_reg = 0, txBusy = 0, NRZI level = J.
- A txReqSendPacket that arrives while txBusy = 1 is ignored, not queued.
- Bit times per packet = 8 + 8·N + stuffed bits + EOP_SE0_BITS + 1.

Optional Feature:
- Macro: USB_TX_AUTO_CRC16_EN.
- Defined:
  - The CRC16 (poly 0x8005, init 0xFFFF) is computed over bytes after the PID when PID[1:0] == 2'b11.
  - When payload ends (txDataValid = 0 at a boundary), enter TX_CRC and send the 16 inverted CRC bits LSB-of-residue first. These bits are stuffed and NRZI-encoded like data, then go to EOP.
  - txAcceptData stays 0 throughout TX_CRC.
- Undefined:
  - TX_CRC and the CRC logic are absent.
  - The caller supplies the CRC bytes as ordinary payload.

Test Plan:
- ACK: request, PID 0xD2, then txDataValid = 0 -> line KJKJKJKK, JJKJJKKK, SE0, SE0, J. outEN_reg high for exactly 19 cycles; txAcceptData pulses once.
- Stuffing: PID 0x4B then payload 0xFF -> a stuffed 0 is inserted after the 6th one of 0xFF. The payload byte spans 9 bit times; total outEN_reg high cycles = 28.
- Boundary stuff before EOP: payload ending in six 1s (0xFC as last byte) -> one stuffed bit (line toggles) precedes the first SE0.
- Back-to-back: a second request held high during txBusy is ignored. A request asserted the cycle after txBusy falls starts a new SYNC one cycle later.
- Reset mid-packet: assert RST during payload bit 3 -> next edge gives J, outEN_reg = 0, txBusy = 0, with no SE0 emitted. A following packet is bit-exact to the ACK case.
- With USB_TX_AUTO_CRC16_EN: DATA0 (0xC3) with empty payload -> CRC bytes 0x00 0x00 emitted (16 zeros, NRZI toggling every bit), then EOP. txAcceptData pulses exactly once.
